// File: rtl/paged_nent_memory.sv
// Paged stub memory: NPAGES pages of PAGE_DEPTH words, with internal per-page append counters,
// sticky overflow flags, per-page clear and a valid/hit-tagged read pipeline.
module paged_nent_memory #(
  parameter int RAM_WIDTH       = 18,
  parameter int NPAGES          = 8,
  parameter int PAGE_DEPTH      = 128,
  parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                                          clka,
  input  logic                                          rstb,
  input  logic                                          wr_en,
  input  logic [$clog2(NPAGES)-1:0]                     wr_page,
  input  logic [RAM_WIDTH-1:0]                          wr_data,
  input  logic                                          clr_en,
  input  logic [$clog2(NPAGES)-1:0]                     clr_page,
  input  logic                                          rd_en,
  input  logic [$clog2(NPAGES)-1:0]                     rd_page,
  input  logic [$clog2(PAGE_DEPTH)-1:0]                 rd_idx,
  input  logic                                          regceb,
  output logic [RAM_WIDTH-1:0]                          doutb,
  output logic                                          rd_valid,
  output logic                                          rd_hit,
  output logic [NPAGES*($clog2(PAGE_DEPTH)+1)-1:0]      nent_o,
  output logic [NPAGES-1:0]                             ovf_o
);

  localparam int PW    = $clog2(NPAGES);
  localparam int AW    = $clog2(PAGE_DEPTH);
  localparam int NW    = AW + 1;
  localparam int DEPTH = NPAGES * PAGE_DEPTH;

  logic [RAM_WIDTH-1:0] mem [DEPTH];
  logic [NW-1:0]        nent_all [NPAGES];

  logic          clr_same;
  logic          wr_full;
  logic          wr_do;
  logic [AW-1:0] wr_idx;
  logic          rd_hit_d;

  // A same-cycle clear of the target page frees it, so the append lands at index 0.
  assign clr_same = clr_en && (clr_page == wr_page);
  assign wr_full  = (nent_all[wr_page] == NW'(PAGE_DEPTH));
  assign wr_do    = wr_en && !rstb && (clr_same || !wr_full);
  assign wr_idx   = clr_same ? '0 : nent_all[wr_page][AW-1:0];
  assign rd_hit_d = ({1'b0, rd_idx} < nent_all[rd_page]);

  always_ff @(posedge clka) begin
    if (wr_do) begin
      mem[{wr_page, wr_idx}] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPAGES; gi++) begin : g_page
      logic          clr_p;
      logic          wr_p;
      logic [NW-1:0] cnt_q;
      logic [NW-1:0] cnt_d;
      logic          ovf_q;
      logic          ovf_d;

      assign clr_p = clr_en && (clr_page == PW'(gi));
      assign wr_p  = wr_en && (wr_page == PW'(gi));

      always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_p) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end
        if (wr_p) begin
          if (cnt_d == NW'(PAGE_DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_d + NW'(1);
          end
        end
      end

      always_ff @(posedge clka) begin
        if (rstb) begin
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          ovf_q <= ovf_d;
        end
      end

      assign nent_all[gi]          = cnt_q;
      assign nent_o[gi*NW +: NW]   = cnt_q;
      assign ovf_o[gi]             = ovf_q;
    end
  endgenerate

  // Stage 1: block RAM read register (read-first), with the hit bit riding alongside.
  logic [RAM_WIDTH-1:0] rd_q;
  logic                 v1_q;
  logic                 h1_q;

  always_ff @(posedge clka) begin
    if (rstb) begin
      rd_q <= '0;
      v1_q <= 1'b0;
      h1_q <= 1'b0;
    end else begin
      v1_q <= rd_en;
      h1_q <= rd_en && rd_hit_d;
      if (rd_en) begin
        rd_q <= mem[{rd_page, rd_idx}];
      end
    end
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_ll
      logic unused_regceb;
      assign unused_regceb = regceb;
      assign doutb    = rd_q;
      assign rd_valid = v1_q;
      assign rd_hit   = h1_q;
    end else begin : g_hp
      logic [RAM_WIDTH-1:0] dout2_q;
      logic                 v2_q;
      logic                 h2_q;

      // Output register freezes entirely while regceb is low; stage 1 keeps moving.
      always_ff @(posedge clka) begin
        if (rstb) begin
          dout2_q <= '0;
          v2_q    <= 1'b0;
          h2_q    <= 1'b0;
        end else if (regceb) begin
          v2_q <= v1_q;
          h2_q <= h1_q;
          if (v1_q) begin
            dout2_q <= rd_q;
          end
        end
      end

      assign doutb    = dout2_q;
      assign rd_valid = v2_q;
      assign rd_hit   = h2_q;
    end
  endgenerate

endmodule

// File: doc/paged_nent_memory.md
# paged_nent_memory

Parametrised successor to the fixed 8-page memory with externally supplied entry counts. It stores stub words in NPAGES pages of PAGE_DEPTH entries each and maintains per-page entry counters internally: writes are appended at the page's current count, and per-page clear, overflow detection and a valid-tagged read pipeline are included. It sits between a producing processing module (writer, one page per BX slot) and a consuming module (reader), all on one clock.

## Interface
- RAM_WIDTH, 18, data word width
- NPAGES, 8, number of pages; power of 2, ≥2
- PAGE_DEPTH, 128, entries per page; power of 2, ≥2
- RAM_PERFORMANCE, "HIGH_PERFORMANCE", "HIGH_PERFORMANCE" gives 2-cycle read latency; "LOW_LATENCY" gives 1 cycle
- Derived: PW = clog2(NPAGES), AW = clog2(PAGE_DEPTH), NW = AW+1
- clka  in  1  clock; all logic rising-edge
- rstb  in  1  reset, synchronous, active-high; clock clka
- wr_en  in  1  append wr_data to page wr_page
- wr_page  in  PW  target page of append
- wr_data  in  RAM_WIDTH  data to append
- clr_en  in  1  zero entry count of page clr_page
- clr_page  in  PW  page to clear
- rd_en  in  1  issue read
- rd_page  in  PW  read page
- rd_idx  in  AW  entry index within page
- regceb  in  1  output register enable (HIGH_PERFORMANCE only; ignored otherwise)
- doutb  out  RAM_WIDTH  read data
- rd_valid  out  1  doutb carries result of an issued read
- rd_hit  out  1  qualifies rd_valid: rd_idx was < nent of rd_page at issue
- nent_o  out  NPAGES*NW  flattened counts; page p in bits [p*NW +: NW]
- ovf_o  out  NPAGES  sticky per-page overflow flags

## Operation
- Storage: RAM_WIDTH × NPAGES*PAGE_DEPTH block RAM. Physical address = {page, idx}. Contents are not reset and not initialised; the bench must not rely on them before they are written.
- Append: if wr_en and nent[wr_page] < PAGE_DEPTH:
  - RAM[{wr_page, nent[wr_page][AW-1:0]}] <= wr_data
  - nent[wr_page] increments
- Full page: if wr_en and nent[wr_page] == PAGE_DEPTH, the write is dropped, nent holds, and ovf[wr_page] is set.
- Counts saturate at PAGE_DEPTH and never wrap.
- Clear: clr_en sets nent[clr_page] <= 0 and ovf[clr_page] <= 0. RAM contents are untouched.
- Clear and write to the same page in the same cycle: clear takes effect first. The data lands at idx 0, nent = 1, ovf = 0.
- Clear and write to different pages in the same cycle: both take effect independently.
- Read: on rd_en, read RAM[{rd_page, rd_idx}]. The hit bit = (rd_idx < nent[rd_page]), using the pre-edge count. The hit bit travels with the data through the pipeline.
- Read-during-write to the same physical address: read-first; returns the old word, and hit uses the old count.
- No handshake backpressure: one write and one read accepted every cycle.
- Reset clears: all nent, all ovf, doutb = 0, rd_valid = 0, rd_hit = 0, and all pipeline valid bits. An in-flight read is discarded on the cycle rstb is sampled high. wr_en/clr_en/rd_en are ignored while rstb = 1.

## Timing
- nent_o and ovf_o are registered: they reflect a write/clear issued in cycle N from cycle N+1.
- LOW_LATENCY: rd_en at edge N gives doutb/rd_valid/rd_hit valid after edge N+1, held until the next update.
  - rd_valid is high for exactly one cycle per read; doutb holds its last value when rd_valid = 0.
- HIGH_PERFORMANCE: stage-1 register, then output register gated by regceb.
  - With regceb = 1: result visible after edge N+2.
  - With regceb = 0: output register, rd_valid and rd_hit hold. Stage 1 keeps advancing, so a read passing stage 1 while regceb = 0 is lost; this is caller responsibility.
- Back-to-back reads produce back-to-back rd_valid pulses, in issue order.
- Write-then-read of the same entry: data is visible to a read issued at N+1 or later.

## Test plan
- Reset, then append 0x00011, 0x00022, 0x00033 to page 3 → nent_o page 3 = 3 one cycle after the last write; reads of idx 0..2 return those words in order, with rd_hit = 1, at latency 2 (HIGH_PERFORMANCE).
- Fill page 0 with PAGE_DEPTH=128 writes plus 2 more → nent page 0 = 128, ovf_o[0] = 1, idx 127 holds the 128th word, the extra words are not stored, other pages are unaffected.
- Same-cycle clr_en and wr_en on page 5 (nent 40, ovf 1) with data 0x3FFFF → nent = 1, ovf = 0, idx 0 reads 0x3FFFF.
- Read page 2 idx 4 while nent page 2 = 4 → rd_valid = 1, rd_hit = 0. Repeat with LOW_LATENCY → result appears at latency 1.
- Read issued and rstb asserted the next cycle → no rd_valid pulse; doutb = 0; all nent = 0 and ovf = 0 after the reset cycle.
- Hold regceb = 0 for 3 cycles with rd_valid high → doutb, rd_valid and rd_hit stay constant; pulsing regceb resumes updates.
